nios_debug_scan_master: RTL and testbench

NIOS_DEBUG_SCAN_MASTER -- requirements
Module: nios_debug_scan_master

---
 rtl/nios_debug_scan_pkg.sv | 19 +
 rtl/nios_debug_scan_shreg.sv | 30 +++
 rtl/nios_debug_scan_master.sv | 144 ++++++++++++++
 tb/tb_nios_debug_scan_master.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/nios_debug_scan_pkg.sv
// rtl/nios_debug_scan_pkg.sv - shared state encoding and virtual IR codes for the debug scan master
package nios_debug_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RSP  = 3'd6
    } scan_state_t;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

endpackage

// File: rtl/nios_debug_scan_shreg.sv
// rtl/nios_debug_scan_shreg.sv - DR load/shift register, LSB out first, serial in at the MSB
module nios_debug_scan_shreg #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh <= '0;
        end else if (load) begin
            sh <= load_data;
        end else if (shift) begin
            sh <= {serial_in, sh[WIDTH-1:1]};
        end
    end

    assign serial_out   = sh[0];
    assign parallel_out = sh;

endmodule

// File: rtl/nios_debug_scan_master.sv
// rtl/nios_debug_scan_master.sv - virtual-JTAG scan sequencer (UIR/CDR/SDR/UDR/RTI) toward the debug slave
// Optional NIOS_DEBUG_SCAN_IR_SKIP_EN: skip UIR when the requested IR is already loaded.
module nios_debug_scan_master
    import nios_debug_scan_pkg::*;
#(
    parameter int DR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_irout,
    output logic [IR_WIDTH-1:0] ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic                tdi,
    input  logic                tdo,
    input  logic [IR_WIDTH-1:0] ir_out
);

    localparam int CNT_W = $clog2(DR_WIDTH + 1);

    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [CNT_W-1:0]    sdr_cnt;
    logic [3:0]          rti_cnt;
    logic                accept;
    logic                ir_hit;
    logic                sdr_last;
    logic                rti_last;
    logic                shift_out;
    logic [DR_WIDTH-1:0] shift_q;

    assign accept   = cmd_valid && cmd_ready;
    assign sdr_last = (sdr_cnt == CNT_W'(DR_WIDTH - 1));
    assign rti_last = (rti_cnt == 4'(RTI_CYCLES - 1));

`ifdef NIOS_DEBUG_SCAN_IR_SKIP_EN
    // ir_in always holds the last IR pushed through UIR, so only a valid flag is needed.
    logic last_ir_valid;
    assign ir_hit = last_ir_valid && (cmd_ir == ir_in);
`else
    assign ir_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ir_hit ? ST_CDR : ST_UIR;
            ST_UIR:  state_nxt = ST_CDR;
            ST_CDR:  state_nxt = ST_SDR;
            ST_SDR:  if (sdr_last) state_nxt = ST_UDR;
            ST_UDR:  state_nxt = ST_RTI;
            ST_RTI:  if (rti_last) state_nxt = ST_RSP;
            ST_RSP:  if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they are registered yet aligned with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b0;
            ir_in          <= '0;
            rsp_data       <= '0;
            rsp_irout      <= '0;
            sdr_cnt        <= '0;
            rti_cnt        <= '0;
`ifdef NIOS_DEBUG_SCAN_IR_SKIP_EN
            last_ir_valid  <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            cmd_ready      <= (state_nxt == ST_IDLE);
            vs_uir         <= (state_nxt == ST_UIR);
            vs_cdr         <= (state_nxt == ST_CDR);
            vs_sdr         <= (state_nxt == ST_SDR);
            vs_udr         <= (state_nxt == ST_UDR);
            jtag_state_rti <= (state_nxt == ST_RTI);
            rsp_valid      <= (state_nxt == ST_RSP);

            if (accept) begin
                ir_in <= cmd_ir;
            end
`ifdef NIOS_DEBUG_SCAN_IR_SKIP_EN
            if (state_nxt == ST_UIR) begin
                last_ir_valid <= 1'b1;
            end
`endif
            if (state == ST_SDR && state_nxt == ST_SDR) begin
                sdr_cnt <= sdr_cnt + CNT_W'(1);
            end else begin
                sdr_cnt <= '0;
            end

            // Only advances while staying in RTI, so it stops at the terminal count.
            if (state == ST_RTI && state_nxt == ST_RTI) begin
                rti_cnt <= rti_cnt + 4'd1;
            end else begin
                rti_cnt <= '0;
            end

            if (state == ST_CDR) begin
                rsp_irout <= ir_out;
            end
            if (state == ST_UDR) begin
                rsp_data <= shift_q;
            end
        end
    end

    nios_debug_scan_shreg #(
        .WIDTH(DR_WIDTH)
    ) u_shreg (
        .clk         (clk),
        .reset       (reset),
        .load        (accept),
        .load_data   (cmd_data),
        .shift       (state == ST_SDR),
        .serial_in   (tdo),
        .serial_out  (shift_out),
        .parallel_out(shift_q)
    );

    assign tdi = vs_sdr & shift_out;

endmodule

// File: tb/tb_nios_debug_scan_master.sv
// tb/tb_nios_debug_scan_master.sv - directed table-driven bench for nios_debug_scan_master
module tb_nios_debug_scan_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]  cmd_ir, rsp_irout, ir_in, ir_out;
    logic [37:0] cmd_data, rsp_data;
    logic        vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, tdi, tdo;

    logic        cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1;
    logic [1:0]  cmd_ir1, rsp_irout1, ir_in1, ir_out1;
    logic [3:0]  cmd_data1, rsp_data1;
    logic        vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1, tdi1, tdo1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios_debug_scan_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_irout(rsp_irout),
        .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .jtag_state_rti(jtag_state_rti), .tdi(tdi), .tdo(tdo), .ir_out(ir_out)
    );

    nios_debug_scan_master #(.DR_WIDTH(4), .IR_WIDTH(2), .RTI_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir1), .cmd_data(cmd_data1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_irout(rsp_irout1),
        .ir_in(ir_in1), .vs_uir(vs_uir1), .vs_cdr(vs_cdr1), .vs_sdr(vs_sdr1), .vs_udr(vs_udr1),
        .jtag_state_rti(rti1), .tdi(tdi1), .tdo(tdo1), .ir_out(ir_out1)
    );

    // Slave model: shifts tdi in at the MSB and drives its LSB, so it returns the previous DR.
    logic [37:0] slv;
    logic [37:0] slv_reset_val;
    assign tdo  = slv[0];
    assign tdo1 = 1'b1;
    always @(posedge clk) begin
        if (reset) slv <= slv_reset_val;
        else if (vs_sdr) slv <= {tdi, slv[37:1]};
    end

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] data;
        logic [1:0]  irout_drv;
        logic [37:0] exp_data;
        logic [1:0]  exp_irout;
        int          hold;
        bit          keep_valid;
        int          exp_lat;
        int          exp_uir;
    } vec_t;

`ifdef NIOS_DEBUG_SCAN_IR_SKIP_EN
    localparam int SKIP_LAT = 43;
    localparam int SKIP_UIR = 0;
`else
    localparam int SKIP_LAT = 44;
    localparam int SKIP_UIR = 1;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int          lat, uir_cnt, sdr_cnt, rti_cnt, excl_err, tdi_err, busy_err, irin_err, hold_err;
        bit          acc;
        logic [37:0] tdi_vec, held;
        lat = 0; uir_cnt = 0; sdr_cnt = 0; rti_cnt = 0;
        excl_err = 0; tdi_err = 0; busy_err = 0; irin_err = 0; hold_err = 0;
        acc = 0; tdi_vec = '0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ir = v.ir; cmd_data = v.data; ir_out = v.irout_drv;
        for (int t = 0; t < 100; t++) begin
            if (cmd_ready) begin acc = 1; break; end
            @(negedge clk);
        end
        check({tag, " accept"}, 64'(acc), 64'd1);
        @(posedge clk); #1;
        if (!v.keep_valid) cmd_valid = 1'b0;
        for (int i = 1; i <= 150; i++) begin
            if ($countones({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, rsp_valid}) > 1) excl_err++;
            if (vs_uir) uir_cnt++;
            if (vs_sdr) begin
                if (sdr_cnt < 38) tdi_vec[sdr_cnt] = tdi;
                sdr_cnt++;
            end else if (tdi) tdi_err++;
            if (jtag_state_rti) rti_cnt++;
            if ((vs_uir || vs_cdr || vs_sdr || vs_udr || jtag_state_rti) && ir_in != v.ir) irin_err++;
            if (rsp_valid) begin lat = i; break; end
            if (cmd_ready) busy_err++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " uir_cycles"}, 64'(uir_cnt), 64'(v.exp_uir));
        check({tag, " sdr_cycles"}, 64'(sdr_cnt), 64'd38);
        check({tag, " rti_cycles"}, 64'(rti_cnt), 64'd2);
        check({tag, " tdi_seq"}, 64'(tdi_vec), 64'(v.data));
        check({tag, " strobe_onehot_err"}, 64'(excl_err), 64'd0);
        check({tag, " tdi_outside_sdr"}, 64'(tdi_err), 64'd0);
        check({tag, " ready_while_busy"}, 64'(busy_err), 64'd0);
        check({tag, " ir_in_err"}, 64'(irin_err), 64'd0);
        check({tag, " rsp_data"}, 64'(rsp_data), 64'(v.exp_data));
        check({tag, " rsp_irout"}, 64'(rsp_irout), 64'(v.exp_irout));
        held = rsp_data;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_data != held || rsp_irout != v.exp_irout || cmd_ready) hold_err++;
        end
        if (v.hold > 0) check({tag, " hold_err"}, 64'(hold_err), 64'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " back_to_idle"}, {62'd0, cmd_ready, rsp_valid}, 64'b10);
    endtask

    vec_t vecs[4];
    int   sdr_seen, err, lat1, rti1_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd2, 38'h2A_AAAA_AAAA, 2'b01, 38'h15_5555_5555, 2'b01, 0,  1'b0, 44, 1};
        vecs[1] = '{2'd1, 38'h3F_0000_FFFF, 2'b11, 38'h2A_AAAA_AAAA, 2'b11, 10, 1'b0, 44, 1};
        vecs[2] = '{2'd1, 38'h00_1234_5678, 2'b10, 38'h3F_0000_FFFF, 2'b10, 0,  1'b0, SKIP_LAT, SKIP_UIR};
        vecs[3] = '{2'd0, 38'h01_8000_0001, 2'b00, 38'h00_1234_5678, 2'b00, 0,  1'b1, 44, 1};

        reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0; ir_out = '0;
        cmd_valid1 = 1'b0; cmd_ir1 = '0; cmd_data1 = '0; rsp_ready1 = 1'b1; ir_out1 = 2'b11;
        slv_reset_val = 38'h15_5555_5555;
        repeat (3) @(posedge clk);
        #1;
        check("reset cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, tdi}), 64'd0);
        check("reset ir_in", 64'(ir_in), 64'd0);
        check("reset rsp_data", 64'(rsp_data), 64'd0);
        check("reset rsp_irout", 64'(rsp_irout), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 4; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

        // Reset on the 20th SDR cycle discards the scan.
        slv_reset_val = 38'h12_3456_789A;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ir = 2'd3; cmd_data = 38'h0F_0F0F_0F0F;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        sdr_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (vs_sdr) sdr_seen++;
            if (sdr_seen == 20) break;
            @(posedge clk); #1;
        end
        check("midsdr reached", 64'(sdr_seen), 64'd20);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midsdr idle", {62'd0, cmd_ready, rsp_valid}, 64'b10);
        check("midsdr strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, tdi}), 64'd0);
        check("midsdr ir_in", 64'(ir_in), 64'd0);
        err = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || !cmd_ready) err++;
        end
        check("midsdr no_rsp", 64'(err), 64'd0);
        run_vec("post_reset", '{2'd0, 38'h2A_AAAA_AAAA, 2'b10, 38'h12_3456_789A, 2'b10, 0, 1'b0, 44, 1});

        // RTI_CYCLES=1 instance: 4-bit DR, tdo tied high, ir_out=11.
        @(negedge clk);
        check("dut1 ready", 64'(cmd_ready1), 64'd1);
        cmd_valid1 = 1'b1; cmd_ir1 = 2'd2; cmd_data1 = 4'h5;
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        lat1 = 0; rti1_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (rti1) rti1_cnt++;
            if (rsp_valid1) begin lat1 = i; break; end
            @(posedge clk); #1;
        end
        check("dut1 latency", 64'(lat1), 64'd9);
        check("dut1 rti_cycles", 64'(rti1_cnt), 64'd1);
        check("dut1 rsp_data", 64'(rsp_data1), 64'hF);
        check("dut1 rsp_irout", 64'(rsp_irout1), 64'b11);
        @(posedge clk); #1;
        check("dut1 back_to_idle", {62'd0, cmd_ready1, rsp_valid1}, 64'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
